// File: rtl/pe_id_generator_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pe_id_pkg
//  Description : Shared constants, types and the small divide helper used by
//                the PE ID generator and its per-row calculator.
//  Revision    : 1.0 - initial release
// ============================================================================
package pe_id_pkg;

    localparam int H_MAX = 6;
    localparam int W_MAX = 8;

    localparam int XID_W = 5;
    localparam int YID_W = 3;

    localparam logic [XID_W-1:0] XID_INVALID = 5'd31;
    localparam logic [YID_W-1:0] YID_INVALID = 3'd7;

    typedef struct packed {
        logic [3:0] quo;
        logic [3:0] rem;
    } divmod_t;

    // Quotient/remainder by repeated compare-and-subtract. Numerators seen by
    // this block never exceed 7, so eight steps always finish the division.
    // A zero divisor leaves quo=0 and rem=n rather than running away.
    function automatic divmod_t divmod4(input logic [3:0] n, input logic [3:0] d);
        divmod_t res;
        res.quo = 4'd0;
        res.rem = n;
        for (int k = 0; k < 8; k++) begin
            if ((d != 4'd0) && (res.rem >= d)) begin
                res.rem = res.rem - d;
                res.quo = res.quo + 4'd1;
            end
        end
        return res;
    endfunction

endpackage : pe_id_pkg
`default_nettype wire

// File: rtl/pe_id_generator_seq_row_calc.sv
`default_nettype none
// ============================================================================
//  Module      : pe_id_row_calc
//  Description : Decomposes one physical PE row into kernel-row index (i),
//                channel-group index (rr) and chain index (th), and flags
//                whether the row is active and whether it is the top or the
//                bottom of its psum accumulation chain.
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_id_row_calc
    import pe_id_pkg::*;
#(
    parameter int ROW = 0
) (
    input  logic [1:0] i_Re,
    input  logic [2:0] i_re,
    input  logic [2:0] i_row_lim,
    input  logic       i_legal,
    output logic [1:0] o_i,
    output logic [2:0] o_rr,
    output logic [2:0] o_th,
    output logic       o_active,
    output logic       o_top,
    output logic       o_bottom
);

    divmod_t    w_row_dm;
    divmod_t    w_vs_dm;
    logic [3:0] w_vs;

    // y = vs*Re + i
    assign w_row_dm = divmod4(4'(ROW), {2'b00, i_Re});
    assign w_vs     = w_row_dm.quo;

    // vs = th*re + rr
    assign w_vs_dm  = divmod4(w_vs, {1'b0, i_re});

    assign o_i      = w_row_dm.rem[1:0];
    assign o_rr     = w_vs_dm.rem[2:0];
    assign o_th     = w_vs_dm.quo[2:0];

    assign o_active = i_legal && (3'(ROW) < i_row_lim);

    // Psum flows upward: the chain's top row emits the finished opsum, its
    // bottom row is where the incoming ipsum enters.
    assign o_top    = (o_i == 2'd0) && (o_rr == 3'd0);
    assign o_bottom = (o_i == (i_Re - 2'd1)) && (o_rr == (i_re - 3'd1));

    // Upper quotient/remainder bits are provably zero for legal inputs.
    logic w_unused_bits;
    assign w_unused_bits = ^{w_row_dm.rem[3:2], w_vs_dm.quo[3], w_vs_dm.rem[3]};

endmodule : pe_id_row_calc
`default_nettype wire

// File: rtl/pe_id_generator_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pe_id_generator_seq
//  Description : Registered X/Y-ID and psum local-network chaining generator
//                for the 6x8 PE array. Outputs follow the layer mapping
//                inputs with one cycle of latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_id_generator_seq
    import pe_id_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic [2:0]                       PE_ARRAY_H,
    input  logic [3:0]                       PE_ARRAY_W,
    input  logic [1:0]                       KERNEL_H,
    input  logic [2:0]                       p,
    input  logic [2:0]                       q,
    input  logic [2:0]                       r,
    input  logic [2:0]                       t,
    input  logic [5:0]                       e,
    input  logic [2:0]                       t_H,
    input  logic [3:0]                       t_W,
    input  logic [1:0]                       U,
    input  logic                             LINEAR,
    output logic [H_MAX*W_MAX*XID_W-1:0]     filter_XID,
    output logic [H_MAX*YID_W-1:0]           filter_YID,
    output logic [H_MAX*W_MAX*XID_W-1:0]     ifmap_XID,
    output logic [H_MAX*YID_W-1:0]           ifmap_YID,
    output logic [H_MAX*W_MAX*XID_W-1:0]     ipsum_XID,
    output logic [H_MAX*YID_W-1:0]           ipsum_YID,
    output logic [H_MAX*W_MAX*XID_W-1:0]     opsum_XID,
    output logic [H_MAX*YID_W-1:0]           opsum_YID,
    output logic [H_MAX-2:0]                 LN_config
);

    // p, q and t describe work per PE but do not influence any ID.
    logic w_unused_ok;
    assign w_unused_ok = ^{p, q, t};

    // ------------------------------------------------------------------
    // Effective mapping parameters and active-region limits
    // ------------------------------------------------------------------
    logic [1:0] w_Re;
    logic [2:0] w_re;
    logic [1:0] w_Ue;
    logic [7:0] w_rows_used;
    logic [9:0] w_cols_used;
    logic [2:0] w_row_lim;
    logic [3:0] w_col_lim;
    logic       w_legal;

    // Fold LINEAR into the effective parameters and clamp the active region.
    always_comb begin
        w_Re        = LINEAR ? 2'd1 : KERNEL_H;
        w_re        = LINEAR ? 3'd1 : r;
        w_Ue        = LINEAR ? 2'd1 : U;
        w_rows_used = LINEAR ? {5'd0, PE_ARRAY_H}
                             : (8'(w_Re) * 8'(w_re) * 8'(t_H));
        w_cols_used = 10'(e) * 10'(t_W);

        w_legal = (e != 6'd0) && (e <= 6'd8) && (KERNEL_H != 2'd0) &&
                  (r != 3'd0) && (t_H != 3'd0) && (t_W != 4'd0);

        w_row_lim = 3'(H_MAX);
        if (w_rows_used < 8'(H_MAX))
            w_row_lim = w_rows_used[2:0];
        if (PE_ARRAY_H < w_row_lim)
            w_row_lim = PE_ARRAY_H;

        w_col_lim = 4'(W_MAX);
        if (w_cols_used < 10'(W_MAX))
            w_col_lim = w_cols_used[3:0];
        if (PE_ARRAY_W < w_col_lim)
            w_col_lim = PE_ARRAY_W;
    end

    // ------------------------------------------------------------------
    // Row decomposition
    // ------------------------------------------------------------------
    logic [H_MAX-1:0] w_row_act;
    logic [H_MAX-1:0] w_row_top;
    logic [H_MAX-1:0] w_row_bot;
    logic [1:0]       w_row_i  [H_MAX];
    logic [2:0]       w_row_rr [H_MAX];
    logic [2:0]       w_row_th [H_MAX];

    generate
        for (genvar gy = 0; gy < H_MAX; gy++) begin : g_row
            pe_id_row_calc #(
                .ROW (gy)
            ) u_row_calc (
                .i_Re      (w_Re),
                .i_re      (w_re),
                .i_row_lim (w_row_lim),
                .i_legal   (w_legal),
                .o_i       (w_row_i[gy]),
                .o_rr      (w_row_rr[gy]),
                .o_th      (w_row_th[gy]),
                .o_active  (w_row_act[gy]),
                .o_top     (w_row_top[gy]),
                .o_bottom  (w_row_bot[gy])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Column decomposition: x = hs*e + j
    // ------------------------------------------------------------------
    logic [3:0]       w_col_hs [W_MAX];
    logic [3:0]       w_col_j  [W_MAX];
    logic [W_MAX-1:0] w_col_act;

    generate
        for (genvar gx = 0; gx < W_MAX; gx++) begin : g_col
            divmod_t w_dm;
            assign w_dm          = divmod4(4'(gx), e[3:0]);
            assign w_col_hs[gx]  = w_dm.quo;
            assign w_col_j[gx]   = w_dm.rem;
            assign w_col_act[gx] = w_legal && (4'(gx) < w_col_lim);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state ID tables
    // ------------------------------------------------------------------
    logic [H_MAX*W_MAX-1:0][XID_W-1:0] w_fx, w_ix, w_px, w_ox;
    logic [H_MAX-1:0][YID_W-1:0]       w_fy, w_iy, w_py, w_oy;
    logic [H_MAX-2:0]                  w_ln;

    // Build every XID/YID and the chaining mask from the decompositions.
    always_comb begin
        for (int y = 0; y < H_MAX; y++) begin
            w_fy[y] = YID_INVALID;
            w_iy[y] = YID_INVALID;
            w_py[y] = YID_INVALID;
            w_oy[y] = YID_INVALID;
            if (w_row_act[y]) begin
                w_fy[y] = 3'(y);
                w_iy[y] = w_row_rr[y];
                w_py[y] = w_row_bot[y] ? w_row_th[y] : YID_INVALID;
                w_oy[y] = w_row_top[y] ? w_row_th[y] : YID_INVALID;
            end
            for (int x = 0; x < W_MAX; x++) begin
                w_fx[y*W_MAX+x] = XID_INVALID;
                w_ix[y*W_MAX+x] = XID_INVALID;
                w_px[y*W_MAX+x] = XID_INVALID;
                w_ox[y*W_MAX+x] = XID_INVALID;
                if (w_row_act[y] && w_col_act[x]) begin
                    w_fx[y*W_MAX+x] = 5'(w_col_hs[x]);
                    w_ix[y*W_MAX+x] = (5'(w_col_j[x]) * {3'b000, w_Ue}) +
                                      {3'b000, w_row_i[y]};
                    w_px[y*W_MAX+x] = w_row_bot[y] ? 5'(x) : XID_INVALID;
                    w_ox[y*W_MAX+x] = w_row_top[y] ? 5'(x) : XID_INVALID;
                end
            end
        end
        for (int k = 0; k < H_MAX-1; k++) begin
            w_ln[k] = w_row_act[k] && w_row_act[k+1] &&
                      (w_row_th[k] == w_row_th[k+1]);
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic [H_MAX*W_MAX-1:0][XID_W-1:0] r_fx, r_ix, r_px, r_ox;
    logic [H_MAX-1:0][YID_W-1:0]       r_fy, r_iy, r_py, r_oy;
    logic [H_MAX-2:0]                  r_ln;

    // Capture the tables every cycle; reset forces every tag to invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < H_MAX*W_MAX; n++) begin
                r_fx[n] <= XID_INVALID;
                r_ix[n] <= XID_INVALID;
                r_px[n] <= XID_INVALID;
                r_ox[n] <= XID_INVALID;
            end
            for (int y = 0; y < H_MAX; y++) begin
                r_fy[y] <= YID_INVALID;
                r_iy[y] <= YID_INVALID;
                r_py[y] <= YID_INVALID;
                r_oy[y] <= YID_INVALID;
            end
            r_ln <= '0;
        end else begin
            r_fx <= w_fx;
            r_ix <= w_ix;
            r_px <= w_px;
            r_ox <= w_ox;
            r_fy <= w_fy;
            r_iy <= w_iy;
            r_py <= w_py;
            r_oy <= w_oy;
            r_ln <= w_ln;
        end
    end

    assign filter_XID = r_fx;
    assign filter_YID = r_fy;
    assign ifmap_XID  = r_ix;
    assign ifmap_YID  = r_iy;
    assign ipsum_XID  = r_px;
    assign ipsum_YID  = r_py;
    assign opsum_XID  = r_ox;
    assign opsum_YID  = r_oy;
    assign LN_config  = r_ln;

endmodule : pe_id_generator_seq
`default_nettype wire

// File: tb/tb_pe_id_generator_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pe_id_generator_seq
//  Description : Self-checking bench for pe_id_generator_seq: directed
//                configurations followed by random ones, all compared against
//                an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_id_generator_seq;

    logic         clk;
    logic         rst;
    logic [2:0]   PE_ARRAY_H;
    logic [3:0]   PE_ARRAY_W;
    logic [1:0]   KERNEL_H;
    logic [2:0]   p, q, r, t;
    logic [5:0]   e;
    logic [2:0]   t_H;
    logic [3:0]   t_W;
    logic [1:0]   U;
    logic         LINEAR;
    logic [239:0] filter_XID, ifmap_XID, ipsum_XID, opsum_XID;
    logic [17:0]  filter_YID, ifmap_YID, ipsum_YID, opsum_YID;
    logic [4:0]   LN_config;

    int tests = 0;
    int fails = 0;

    logic [239:0] x_fx, x_ix, x_px, x_ox;
    logic [17:0]  x_fy, x_iy, x_py, x_oy;
    logic [4:0]   x_ln;

    pe_id_generator_seq dut (
        .clk        (clk),
        .rst        (rst),
        .PE_ARRAY_H (PE_ARRAY_H),
        .PE_ARRAY_W (PE_ARRAY_W),
        .KERNEL_H   (KERNEL_H),
        .p          (p),
        .q          (q),
        .r          (r),
        .t          (t),
        .e          (e),
        .t_H        (t_H),
        .t_W        (t_W),
        .U          (U),
        .LINEAR     (LINEAR),
        .filter_XID (filter_XID),
        .filter_YID (filter_YID),
        .ifmap_XID  (ifmap_XID),
        .ifmap_YID  (ifmap_YID),
        .ipsum_XID  (ipsum_XID),
        .ipsum_YID  (ipsum_YID),
        .opsum_XID  (opsum_XID),
        .opsum_YID  (opsum_YID),
        .LN_config  (LN_config)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs after reset: every tag invalid, no chaining.
    task automatic model_reset();
        x_fx = '1; x_ix = '1; x_px = '1; x_ox = '1;
        x_fy = '1; x_iy = '1; x_py = '1; x_oy = '1;
        x_ln = '0;
    endtask

    // Reference mapping computed directly with integer divide/modulo.
    task automatic model();
        int re_k, re_c, ue, rows, cols, rl, cl, n;
        int vs, ii, rr, th, hs, jj;
        int th_of [6];
        bit act [6];
        bit legal;
        model_reset();
        re_k  = LINEAR ? 1 : int'(KERNEL_H);
        re_c  = LINEAR ? 1 : int'(r);
        ue    = LINEAR ? 1 : int'(U);
        rows  = LINEAR ? int'(PE_ARRAY_H) : re_k * re_c * int'(t_H);
        cols  = int'(e) * int'(t_W);
        legal = !(e == 0 || e > 8 || KERNEL_H == 0 || r == 0 || t_H == 0 || t_W == 0);
        rl = rows;
        if (int'(PE_ARRAY_H) < rl) rl = int'(PE_ARRAY_H);
        if (rl > 6) rl = 6;
        cl = cols;
        if (int'(PE_ARRAY_W) < cl) cl = int'(PE_ARRAY_W);
        if (cl > 8) cl = 8;
        if (!legal) begin
            rl = 0;
            cl = 0;
        end
        for (int y = 0; y < 6; y++) begin
            act[y]   = (y < rl);
            th_of[y] = 0;
            if (act[y]) begin
                vs = y / re_k;
                ii = y % re_k;
                rr = vs % re_c;
                th = vs / re_c;
                th_of[y] = th;
                x_fy[y*3 +: 3] = 3'(y);
                x_iy[y*3 +: 3] = 3'(rr);
                if (ii == re_k - 1 && rr == re_c - 1) x_py[y*3 +: 3] = 3'(th);
                if (ii == 0 && rr == 0)               x_oy[y*3 +: 3] = 3'(th);
                for (int x = 0; x < cl; x++) begin
                    hs = x / int'(e);
                    jj = x % int'(e);
                    n  = (y * 8 + x) * 5;
                    x_fx[n +: 5] = 5'(hs);
                    x_ix[n +: 5] = 5'(jj * ue + ii);
                    if (ii == re_k - 1 && rr == re_c - 1) x_px[n +: 5] = 5'(x);
                    if (ii == 0 && rr == 0)               x_ox[n +: 5] = 5'(x);
                end
            end
        end
        for (int k = 0; k < 5; k++)
            x_ln[k] = act[k] && act[k+1] && (th_of[k] == th_of[k+1]);
    endtask

    task automatic check(input string tag, input logic [239:0] obs, input logic [239:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".filter_XID"}, filter_XID, x_fx);
        check({tag, ".filter_YID"}, 240'(filter_YID), 240'(x_fy));
        check({tag, ".ifmap_XID"},  ifmap_XID,  x_ix);
        check({tag, ".ifmap_YID"},  240'(ifmap_YID),  240'(x_iy));
        check({tag, ".ipsum_XID"},  ipsum_XID,  x_px);
        check({tag, ".ipsum_YID"},  240'(ipsum_YID),  240'(x_py));
        check({tag, ".opsum_XID"},  opsum_XID,  x_ox);
        check({tag, ".opsum_YID"},  240'(opsum_YID),  240'(x_oy));
        check({tag, ".LN_config"},  240'(LN_config),  240'(x_ln));
    endtask

    task automatic set_cfg(input int ph, input int pw, input int kh, input int rv,
                           input int ev, input int th, input int tw, input int uv,
                           input int lin);
        PE_ARRAY_H = 3'(ph);
        PE_ARRAY_W = 4'(pw);
        KERNEL_H   = 2'(kh);
        r          = 3'(rv);
        e          = 6'(ev);
        t_H        = 3'(th);
        t_W        = 4'(tw);
        t          = 3'(th * tw);
        U          = 2'(uv);
        LINEAR     = 1'(lin);
        p          = 3'($urandom_range(7));
        q          = 3'($urandom_range(7));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        set_cfg(6, 8, 3, 2, 2, 1, 4, 1, 0);

        // Reset held for two cycles.
        step();
        step();
        model_reset();
        check_all("reset");

        // Baseline mapping.
        rst = 1'b0;
        step();
        model();
        check_all("baseline");
        check("baseline.LN_const", 240'(LN_config), 240'(5'd31));
        check("baseline.row0_filter", 240'(filter_XID[39:0]),
              240'({5'd3, 5'd3, 5'd2, 5'd2, 5'd1, 5'd1, 5'd0, 5'd0}));

        // Stride 2.
        set_cfg(6, 8, 3, 2, 2, 1, 4, 2, 0);
        step();
        model();
        check_all("stride2");
        check("stride2.row2_ifmap", 240'(ifmap_XID[80*1 +: 10]), 240'({5'd4, 5'd2}));

        // Two accumulation chains.
        set_cfg(6, 8, 3, 1, 2, 2, 4, 1, 0);
        step();
        model();
        check_all("two_chains");
        check("two_chains.LN_const", 240'(LN_config), 240'(5'd27));

        // Fully-connected with partial width.
        set_cfg(6, 8, 3, 2, 4, 1, 1, 1, 1);
        step();
        model();
        check_all("linear");

        // Illegal: e = 0.
        set_cfg(6, 8, 3, 2, 0, 1, 4, 1, 0);
        step();
        model();
        check_all("illegal_e0");

        // Illegal: e > 8.
        set_cfg(6, 8, 3, 2, 9, 1, 1, 1, 0);
        step();
        model();
        check_all("illegal_e9");

        // Mid-operation reset on a valid configuration.
        set_cfg(6, 8, 3, 2, 2, 1, 4, 1, 0);
        step();
        model();
        check_all("pre_midreset");
        rst = 1'b1;
        step();
        model_reset();
        check_all("midreset");
        rst = 1'b0;
        step();
        model();
        check_all("post_midreset");

        // Random configurations, including some illegal ones.
        for (int it = 0; it < 60; it++) begin
            set_cfg($urandom_range(1, 7), $urandom_range(1, 10), $urandom_range(0, 3),
                    $urandom_range(0, 4), $urandom_range(0, 9), $urandom_range(0, 3),
                    $urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 1));
            step();
            model();
            check_all($sformatf("rand%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_pe_id_generator_seq
`default_nettype wire
